// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo FIFO: TX FSM states and case-fold bounds.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic [7:0] CASE_LO    = 8'h61;
  localparam logic [7:0] CASE_HI    = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy level, full/empty flags and a sticky overflow flag.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  rd_ptr;
  logic              rd_ok;
  logic              wr_ok;
  logic              drop;

  // Pointers carry one extra wrap bit so a full FIFO is distinguishable from empty.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign drop  = wr_en && full && !rd_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (overflow_clr) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echoes received UART bytes back through a FIFO and a handshaking TX launcher.
// Build option: ECHO_CASE_FOLD_EN folds lower-case ASCII to upper-case at FIFO write.
//
// state     | meaning
// IDLE      | waiting for enable, a queued byte and an idle transmitter
// LAUNCH    | tx_start pulse, tx_data holds the popped byte
// WAIT_ACK  | waiting for tx_busy to rise, bounded by ACK_TIMEOUT cycles
// WAIT_DONE | transmitter busy, waiting for tx_busy to fall
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   rx_valid,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_error,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  tx_state_t         state;
  logic [TMR_W-1:0]  ack_tmr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              launch;

  always_comb begin
    wr_data = rx_data;
`ifdef ECHO_CASE_FOLD_EN
    if (rx_data >= DATA_W'(CASE_LO) && rx_data <= DATA_W'(CASE_HI)) begin
      wr_data = rx_data - DATA_W'(CASE_DELTA);
    end
`else
`endif
  end

  assign wr_en  = rx_valid && !rx_error;
  assign launch = (state == IDLE) && enable && !empty && !tx_busy;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (launch),
    .rd_data      (rd_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack_tmr  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= LAUNCH;
            tx_start <= 1'b1;
            tx_data  <= rd_data;
          end
        end
        LAUNCH: begin
          state   <= WAIT_ACK;
          ack_tmr <= ACK_LOAD;
        end
        WAIT_ACK: begin
          // A transmitter that never acknowledges still releases the launcher.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_tmr == '0) begin
            state <= IDLE;
          end else begin
            ack_tmr <= ack_tmr - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
